// File: rtl/timer_counter_if.sv
// Software-facing bus of the 64-bit timer/counter.
// Every control input is a level sampled on the rising clock edge; a strobe
// is a one-cycle request with no acknowledge. It takes effect at the edge
// where it is high, and the timer never stalls it.
interface timer_counter_if;
    logic        cnt_en;
    logic        cnt_clr;
    logic [31:0] wdata;
    logic        cnt_wr_lo;
    logic        cnt_wr_hi;
    logic        cmp_wr_lo;
    logic        cmp_wr_hi;
    logic        int_en;
    logic        int_clr;
    logic [63:0] cnt_val;
    logic [63:0] cmp_val;
    logic        int_st;
    logic        tim_int;

    // Driver side: the counter control and register file.
    modport master (
        output cnt_en, cnt_clr, wdata, cnt_wr_lo, cnt_wr_hi,
        output cmp_wr_lo, cmp_wr_hi, int_en, int_clr,
        input  cnt_val, cmp_val, int_st, tim_int
    );

    // Timer side.
    modport slave (
        input  cnt_en, cnt_clr, wdata, cnt_wr_lo, cnt_wr_hi,
        input  cmp_wr_lo, cmp_wr_hi, int_en, int_clr,
        output cnt_val, cmp_val, int_st, tim_int
    );
endinterface

// File: rtl/timer_counter.sv
// 64-bit free-running counter with a 64-bit compare register and a sticky
// interrupt status. The compare match is level-sensitive, so a held match
// keeps re-setting the status after a clear.
module timer_counter (
    input  logic              sys_clk,
    input  logic              sys_rst,
    timer_counter_if.slave    bus
);

    logic [63:0] cnt_q;
    logic [63:0] cmp_q;
    logic        int_q;
    logic        match;

    // Equality is taken on the registered values only.
    assign match = (cnt_q == cmp_q);

    // Counter: clear beats writes, and writes beat the increment.
    // When a write coincides with a count pulse, the pulse is dropped.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= 64'd0;
        end else if (bus.cnt_clr) begin
            cnt_q <= 64'd0;
        end else if (bus.cnt_wr_lo || bus.cnt_wr_hi) begin
            cnt_q[31:0]  <= bus.cnt_wr_lo ? bus.wdata : cnt_q[31:0];
            cnt_q[63:32] <= bus.cnt_wr_hi ? bus.wdata : cnt_q[63:32];
        end else if (bus.cnt_en) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    // Compare register: half-word loads that ignore counter events.
    // Reset to all-ones so that a fresh counter does not match.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cmp_q <= {64{1'b1}};
        end else begin
            if (bus.cmp_wr_lo) begin
                cmp_q[31:0] <= bus.wdata;
            end
            if (bus.cmp_wr_hi) begin
                cmp_q[63:32] <= bus.wdata;
            end
        end
    end

    // Sticky status: a match sets it and beats a simultaneous clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            int_q <= 1'b0;
        end else if (match) begin
            int_q <= 1'b1;
        end else if (bus.int_clr) begin
            int_q <= 1'b0;
        end
    end

    assign bus.cnt_val = cnt_q;
    assign bus.cmp_val = cmp_q;
    assign bus.int_st  = int_q;
    // The enable gates only the output pin, never the status.
    assign bus.tim_int = int_q & bus.int_en;

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there SHALL be no other clock or asynchronous input.
REQ-002 sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-003 sys_rst  in  1  synchronous active-high reset.
REQ-004 cnt_en  in  1  single-cycle count pulse from counter_control; already gated by timer_en, divisor and halt.
REQ-005 cnt_clr  in  1  synchronous clear of the counter to 0.
REQ-006 wdata  in  32  software write data, shared by all write strobes.
REQ-007 cnt_wr_lo / cnt_wr_hi  in  1 each  load wdata into cnt_val[31:0] / cnt_val[63:32].
REQ-008 cmp_wr_lo / cmp_wr_hi  in  1 each  load wdata into cmp_val[31:0] / cmp_val[63:32].
REQ-009 int_en  in  1  interrupt output enable.
REQ-010 int_clr  in  1  write-1-to-clear of int_st.
REQ-011 cnt_val  out  64  current counter value, registered.
REQ-012 cmp_val  out  64  current compare value, registered.
REQ-013 int_st  out  1  sticky interrupt status, registered.
REQ-014 tim_int  out  1  interrupt output = int_st AND int_en, combinational.

Function
REQ-015 Counter update priority per edge SHALL be: sys_rst > cnt_clr > cnt_wr_lo/cnt_wr_hi > cnt_en increment.
REQ-016 cnt_en=1 with no higher-priority event SHALL set cnt_val to cnt_val+1 (64-bit) at that edge, visible the following cycle (latency 1).
REQ-017 Increment of 0xFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 with no other side effect.
REQ-018 cnt_wr_lo alone SHALL load bits [31:0] and hold bits [63:32]; cnt_wr_hi alone is the mirror case; both asserted SHALL load {wdata, wdata}.
REQ-019 A counter write coinciding with cnt_en SHALL suppress the increment for that edge; the pulse is dropped.
REQ-020 cnt_clr coinciding with writes or cnt_en SHALL result in cnt_val=0.
REQ-021 cmp_wr_lo/cmp_wr_hi SHALL load halves with the same rules as REQ-018; compare writes are independent of counter events.
REQ-022 match SHALL be the combinational equality cnt_val == cmp_val, computed on registered values.
REQ-023 match=1 SHALL set int_st at the next edge; if cnt_val reaches cmp_val at edge N, int_st is high after edge N+1.
REQ-024 int_st SHALL remain set until int_clr=1 with match=0; when int_clr and match are both 1 on the same edge, set wins.
REQ-025 The match is level-sensitive: while cnt_val stays equal to cmp_val (cnt_en idle), int_st SHALL re-assert on every edge after a clear.
REQ-026 int_en SHALL only gate tim_int; int_st SHALL set regardless of int_en.
REQ-027 A compare write that makes cmp_val equal to the current cnt_val SHALL set int_st one edge after the write, by REQ-023.

Reset
REQ-028 sys_rst=1 at an edge SHALL force cnt_val=0, cmp_val=0xFFFF_FFFF_FFFF_FFFF, int_st=0; tim_int is therefore 0.
REQ-029 sys_rst SHALL override every concurrent strobe and pulse, including mid-count and with int_st set.
REQ-030 Reset values SHALL produce no match and no interrupt until software writes cmp_val or the counter reaches all-ones.

Verification
REQ-031 Reset, then 5 cnt_en pulses spaced 3 cycles apart -> cnt_val=5; int_st=0; tim_int=0.
REQ-032 Write cmp_val=0x0000_0000_0000_0003 with int_en=1, then pulse cnt_en 3 times -> int_st and tim_int high exactly one cycle after cnt_val becomes 3; int_clr with cnt_val=3 held -> int_st stays 1; one more cnt_en then int_clr -> int_st=0.
REQ-033 Write cnt_val = 0xFFFF_FFFF (wr_hi) and 0xFFFF_FFFE (wr_lo), then 2 cnt_en pulses -> cnt_val sequence 0xFFFF_FFFF_FFFF_FFFF, then 0x0000_0000_0000_0000.
REQ-034 Same edge: cnt_wr_lo with wdata=0x10 and cnt_en, starting from cnt_val=7 -> cnt_val=0x10; same edge cnt_clr and cnt_en -> cnt_val=0.
REQ-035 int_en=0, reach match -> int_st=1 and tim_int=0; set int_en=1 -> tim_int=1 in the same cycle.
REQ-036 Assert sys_rst with cnt_val=0x1234 and int_st=1 while cnt_en pulses -> next cycle cnt_val=0, cmp_val=all-ones, int_st=0.
